// File: rtl/clk_buffer.sv
// clk_buffer: leaf clock buffer. It passes clk_in to clk_out with no phase offset
// through an enable gate that cannot glitch, and it counts the rising edges of
// clk_out since reset.
// Optional feature: define CLK_DIV_EN to add the div_sel port and an integer divider
// that sits ahead of the gate.
`timescale 1ns/1ps

module clk_buffer #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
`ifdef CLK_DIV_EN
  input  logic [DIV_W-1:0] div_sel,
`endif
  output logic             clk_out,
  output logic             clk_active,
  output logic [CNT_W-1:0] edge_cnt
);

  logic             rst_q;
  logic             en_d;
  logic             en_q;
  logic             inc;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Gate input: a reset seen now or at the last posedge closes the gate.
  always_comb begin
    en_d = en & ~rst_q & ~rst;
  end

  // Gate flop updates while clk_in is low, so every clk_out pulse is a full high phase.
  always_ff @(negedge clk_in) begin
    en_q <= en_d;
  end

`ifdef CLK_DIV_EN
  logic [DIV_W-1:0] div_cnt_d;
  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_n_d;
  logic [DIV_W-1:0] div_n_q;
  logic             div_clk_d;
  logic             div_clk_q;
  logic             div_rise;
  logic             bypass;

  assign bypass = (div_n_q == '0);

  // Divider. A new divide ratio is taken only at the terminal count that starts a new period.
  always_comb begin
    div_cnt_d = div_cnt_q;
    div_clk_d = div_clk_q;
    div_n_d   = div_n_q;
    div_rise  = 1'b0;
    if (rst) begin
      div_cnt_d = '0;
      div_clk_d = 1'b0;
      div_n_d   = '0;
    end else if (bypass) begin
      div_cnt_d = '0;
      div_clk_d = 1'b0;
      div_n_d   = div_sel;
    end else if (div_cnt_q == div_n_q - DIV_W'(1)) begin
      div_cnt_d = '0;
      if (div_clk_q) begin
        div_clk_d = 1'b0;
      end else begin
        div_n_d   = div_sel;
        div_clk_d = (div_sel != '0);
        div_rise  = (div_sel != '0);
      end
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
  end

  // Divider state registers.
  always_ff @(posedge clk_in) begin
    div_cnt_q <= div_cnt_d;
    div_clk_q <= div_clk_d;
    div_n_q   <= div_n_d;
  end

  // Gated output. The bypass path and the divided path are both ANDed with the same gate.
  assign clk_out = bypass ? (clk_in & en_q) : (div_clk_q & en_q);

  // A clk_out rising edge occurs on this posedge.
  always_comb begin
    inc = en_q & (bypass | div_rise);
  end
`else
  logic [DIV_W-1:0] unused_div_w;
  assign unused_div_w = '0;

  // Pure gated buffer with zero-delay AND.
  assign clk_out = clk_in & en_q;

  // With the gate open, every clk_in posedge is a clk_out rising edge.
  always_comb begin
    inc = en_q;
  end
`endif

  // Edge counter next state: reset has priority, then a wrapping increment.
  always_comb begin
    cnt_d = cnt_q;
    if (rst) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Reset sampling register and edge counter register.
  always_ff @(posedge clk_in) begin
    rst_q <= rst;
    cnt_q <= cnt_d;
  end

  assign clk_active = en_q;
  assign edge_cnt   = cnt_q;

endmodule

// File: tb/tb_clk_buffer.sv
// tb_clk_buffer: directed vector table plus multi-cycle sequences for clk_buffer.
`timescale 1ns/1ps

module tb_clk_buffer;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        en;
  logic        clk_out;
  logic        clk_active;
  logic [15:0] edge_cnt;

  int checks = 0;
  int errors = 0;

  bit  mon_on    = 1'b0;
  bit  rise_seen = 1'b0;
  time last_rise = 0;
  time prev_rise = 0;
  time in_rise   = 0;

  clk_buffer #(.CNT_W(16), .DIV_W(8)) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .en         (en),
    .clk_out    (clk_out),
    .clk_active (clk_active),
    .edge_cnt   (edge_cnt)
  );

  always #10 clk_in = ~clk_in;

  typedef struct packed {
    logic        rst;
    logic        en;
    logic        act;
    logic        hi;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk_in) in_rise = $time;

  // Every clk_out rise must land on a clk_in rise: clk_in rises at 10 + 20k.
  always @(posedge clk_out) begin
    if (mon_on) begin
      checks++;
      if (($time % 20) != 10) begin
        errors++;
        $display("FAIL clk_out_phase at %0t: rise time mod 20 = %0d expected 10", $time, $time % 20);
      end
      prev_rise = last_rise;
      last_rise = $time;
      rise_seen = 1'b1;
    end
  end

  // Every clk_out pulse must be one full clk_in high phase wide.
  always @(negedge clk_out) begin
    if (mon_on && rise_seen) begin
      checks++;
      if (($time - last_rise) != 10) begin
        errors++;
        $display("FAIL clk_out_width at %0t: got %0d expected 10", $time, $time - last_rise);
      end
    end
  end

  initial begin
    //            rst   en    act   hi    cnt
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'd1};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'd2};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'd3};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd3};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd3};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'd4};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd4};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'd5};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'd1};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'd2};

    rst = 1'b1;
    en  = 1'b1;
    @(posedge clk_in);
    #2;
    mon_on = 1'b1;

    // Each step: inputs change mid high phase, then the low phase and the next high phase are checked.
    for (int i = 0; i < 15; i++) begin
      rst = vecs[i].rst;
      en  = vecs[i].en;
      @(negedge clk_in);
      #2;
      chk($sformatf("v%0d clk_out_low", i), 32'(clk_out), 32'(1'b0));
      chk($sformatf("v%0d clk_active", i), 32'(clk_active), 32'(vecs[i].act));
      @(posedge clk_in);
      #2;
      chk($sformatf("v%0d clk_out_high", i), 32'(clk_out), 32'(vecs[i].hi));
      chk($sformatf("v%0d edge_cnt", i), 32'(edge_cnt), 32'(vecs[i].cnt));
    end

    // en toggled during the low phase, after the gate flop has already sampled it.
    @(negedge clk_in);
    #3;
    en = 1'b0;
    @(posedge clk_in);
    #2;
    chk("lowtog clk_out_still_on", 32'(clk_out), 32'(1'b1));
    chk("lowtog edge_cnt_3", 32'(edge_cnt), 32'd3);
    @(negedge clk_in);
    #2;
    chk("lowtog clk_active_off", 32'(clk_active), 32'(1'b0));
    #3;
    en = 1'b1;
    @(posedge clk_in);
    #2;
    chk("lowtog clk_out_off", 32'(clk_out), 32'(1'b0));
    chk("lowtog edge_cnt_hold", 32'(edge_cnt), 32'd3);
    @(posedge clk_in);
    #2;
    chk("lowtog clk_out_back", 32'(clk_out), 32'(1'b1));
    chk("lowtog edge_cnt_4", 32'(edge_cnt), 32'd4);

    // Run up to 37 edges, then assert reset during a high phase.
    repeat (33) @(posedge clk_in);
    #2;
    chk("midrst edge_cnt_37", 32'(edge_cnt), 32'd37);
    rst = 1'b1;
    #3;
    chk("midrst high_phase_intact", 32'(clk_out), 32'(1'b1));
    @(negedge clk_in);
    #2;
    chk("midrst clk_out_low", 32'(clk_out), 32'(1'b0));
    chk("midrst clk_active_low", 32'(clk_active), 32'(1'b0));
    @(posedge clk_in);
    #2;
    chk("midrst edge_cnt_cleared", 32'(edge_cnt), 32'd0);
    chk("midrst clk_out_stays_low", 32'(clk_out), 32'(1'b0));
    rst = 1'b0;

    // Release, then run 2^16 edges so the counter wraps.
    @(posedge clk_in);
    #2;
    chk("wrap start_cnt", 32'(edge_cnt), 32'd0);
    chk("wrap start_clk_out", 32'(clk_out), 32'(1'b0));
    repeat (65535) @(posedge clk_in);
    #2;
    chk("wrap cnt_max", 32'(edge_cnt), 32'hFFFF);
    @(posedge clk_in);
    #2;
    chk("wrap cnt_zero", 32'(edge_cnt), 32'd0);
    chk("steady period", 32'(last_rise - prev_rise), 32'd20);
    chk("steady phase", 32'(last_rise == in_rise), 32'd1);
    @(posedge clk_in);
    #2;
    chk("wrap cnt_one", 32'(edge_cnt), 32'd1);

    mon_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
